// File: rtl/cpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_seq_pkg
//   Shared definitions for the CPU query sequencer:
//   - state_t : FSM state encoding. The values are visible on the debug
//               'state' port, so they are fixed.
//   - NODE_W_DEF / MAX_QUERIES_DEF : default node width and table depth.
// -----------------------------------------------------------------------------
package cpu_seq_pkg;

  localparam int NODE_W_DEF      = 8;
  localparam int MAX_QUERIES_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_CPU = 3'd1,
    S_RUN       = 3'd2,
    S_GAP       = 3'd3,
    S_DONE      = 3'd4,
    S_ABORT     = 3'd5
  } state_t;

endpackage : cpu_seq_pkg

// File: rtl/query_table.sv
// -----------------------------------------------------------------------------
// query_table
//   MAX_QUERIES-deep table of (start node, end node) pairs. Synchronous write
//   and combinational read. Contents are not reset.
//
// Ports:
//   clk_50M  in   system clock
//   we       in   write enable (already qualified by the caller)
//   wr_idx   in   entry to write
//   wr_sp    in   start node to store
//   wr_ep    in   end node to store
//   rd_idx   in   entry to read
//   rd_sp    out  start node of entry rd_idx
//   rd_ep    out  end node of entry rd_idx
// -----------------------------------------------------------------------------
module query_table
  import cpu_seq_pkg::*;
#(
  parameter int NODE_W      = NODE_W_DEF,
  parameter int MAX_QUERIES = MAX_QUERIES_DEF,
  parameter int IDX_W       = $clog2(MAX_QUERIES)
) (
  input  logic              clk_50M,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [NODE_W-1:0] wr_sp,
  input  logic [NODE_W-1:0] wr_ep,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [NODE_W-1:0] rd_sp,
  output logic [NODE_W-1:0] rd_ep
);

  typedef struct packed {
    logic [NODE_W-1:0] sp;
    logic [NODE_W-1:0] ep;
  } entry_t;

  entry_t mem [MAX_QUERIES];

  // NOTE: the storage array has no reset branch; clearing a register file
  // forces a reset net onto every cell, and software always writes the
  // entries it runs before issuing start.
  always_ff @(posedge clk_50M) begin
    if (we) begin
      mem[wr_idx] <= {wr_sp, wr_ep};
    end
  end

  assign rd_sp = mem[rd_idx].sp;
  assign rd_ep = mem[rd_idx].ep;

endmodule : query_table

// File: rtl/cpu_query_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_query_sequencer
//   Runs a programmed list of (start node, end node) path queries against the
//   path-planning CPU. For each query it presents SP/EP, holds cpu_reset for
//   RST_HOLD cycles, releases it, waits for cpu_done, then idles GAP_CYCLES
//   cycles before the next query.
//
//   Optional feature (macro CPU_TIMEOUT_EN): a RUN phase lasting
//   TIMEOUT_CYCLES cycles without cpu_done aborts the sequence, sets the
//   sticky timeout_err flag and parks the CPU in reset (state ABORT). Without
//   the macro RUN waits forever and timeout_err stays 0.
//
// Ports:
//   clk_50M      in   system clock
//   rst_n        in   synchronous active-low reset
//   wr_en        in   table write strobe (honoured in IDLE/DONE only)
//   wr_idx       in   table entry to write
//   wr_sp/wr_ep  in   start/end node for that entry
//   num_queries  in   queries to run, sampled on an accepted start
//   start        in   one-cycle run request
//   cpu_done     in   CPU finished the current query (sampled in RUN only)
//   SP/EP        out  start/end node presented to the CPU
//   cpu_reset    out  active-high CPU reset
//   busy         out  high in RESET_CPU/RUN/GAP
//   query_idx    out  index of the current query
//   query_done   out  one-cycle pulse when cpu_done is accepted
//   seq_done     out  high in DONE
//   timeout_err  out  sticky abort flag
//   state        out  encoded FSM state (debug)
// -----------------------------------------------------------------------------
module cpu_query_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int NODE_W         = NODE_W_DEF,
  parameter int MAX_QUERIES    = MAX_QUERIES_DEF,
  parameter int IDX_W          = $clog2(MAX_QUERIES),
  parameter int RST_HOLD       = 10000,
  parameter int GAP_CYCLES     = 150000000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W          = 32
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [NODE_W-1:0] wr_sp,
  input  logic [NODE_W-1:0] wr_ep,
  input  logic [IDX_W:0]    num_queries,
  input  logic              start,
  input  logic              cpu_done,
  output logic [NODE_W-1:0] SP,
  output logic [NODE_W-1:0] EP,
  output logic              cpu_reset,
  output logic              busy,
  output logic [IDX_W-1:0]  query_idx,
  output logic              query_done,
  output logic              seq_done,
  output logic              timeout_err,
  output logic [2:0]        state
);

`ifdef CPU_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Terminal counts: every phase clears the counter on entry, so a phase of
  // N cycles ends on the edge where the counter reads N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q;
  logic [CNT_W-1:0]    counter;
  logic [IDX_W:0]      count_q;     // number of queries latched at start
  logic                table_we;
  logic [IDX_W-1:0]    rd_idx;
  logic [NODE_W-1:0]   rd_sp;
  logic [NODE_W-1:0]   rd_ep;
  logic                start_ok;
  logic                last_query;
  logic                can_write;

  // Writes are only honoured while no sequence is in flight.
  assign can_write = (state_q == S_IDLE) || (state_q == S_DONE);
  assign table_we  = wr_en && can_write;

  // Entry 0 is read when launching; entry query_idx+1 when leaving GAP.
  // A write in the launch cycle lands at the edge, so the launch still sees
  // the old contents.
  assign rd_idx = (state_q == S_GAP) ? (query_idx + IDX_W'(1)) : '0;

  assign start_ok = start
                 && (num_queries != '0)
                 && (num_queries <= (IDX_W+1)'(MAX_QUERIES));

  assign last_query = ({1'b0, query_idx} == (count_q - (IDX_W+1)'(1)));

  query_table #(
    .NODE_W      (NODE_W),
    .MAX_QUERIES (MAX_QUERIES),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk_50M (clk_50M),
    .we      (table_we),
    .wr_idx  (wr_idx),
    .wr_sp   (wr_sp),
    .wr_ep   (wr_ep),
    .rd_idx  (rd_idx),
    .rd_sp   (rd_sp),
    .rd_ep   (rd_ep)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below reads the values from before this edge.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      counter     <= '0;
      count_q     <= '0;
      SP          <= '0;
      EP          <= '0;
      cpu_reset   <= 1'b0;
      busy        <= 1'b0;
      query_idx   <= '0;
      query_done  <= 1'b0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      query_done <= 1'b0;

      unique case (state_q)
        // ABORT only becomes reachable with the timeout feature; it launches
        // a fresh run exactly like IDLE and DONE.
        S_IDLE, S_DONE, S_ABORT: begin
          if (start_ok) begin
            count_q     <= num_queries;
            query_idx   <= '0;
            SP          <= rd_sp;
            EP          <= rd_ep;
            cpu_reset   <= 1'b1;
            busy        <= 1'b1;
            counter     <= '0;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
            state_q     <= S_RESET_CPU;
          end
        end

        S_RESET_CPU: begin
          if (counter == RST_LAST) begin
            cpu_reset <= 1'b0;
            counter   <= '0;
            state_q   <= S_RUN;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (cpu_done) begin
            query_done <= 1'b1;
            counter    <= '0;
            if (last_query) begin
              busy     <= 1'b0;
              seq_done <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_GAP;
            end
          end else if (TIMEOUT_EN && (counter == TIMEOUT_LAST)) begin
            timeout_err <= 1'b1;
            cpu_reset   <= 1'b1;
            busy        <= 1'b0;
            counter     <= '0;
            state_q     <= S_ABORT;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (counter == GAP_LAST) begin
            query_idx <= query_idx + IDX_W'(1);
            SP        <= rd_sp;
            EP        <= rd_ep;
            cpu_reset <= 1'b1;
            counter   <= '0;
            state_q   <= S_RESET_CPU;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        default: begin
          cpu_reset <= 1'b0;
          busy      <= 1'b0;
          counter   <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule : cpu_query_sequencer

// File: tb/tb_cpu_query_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_query_sequencer
//   Directed scenarios followed by a randomized phase. A behavioural model
//   (phase + remaining-cycle countdowns) predicts every output each cycle and
//   a compare process checks the DUT on the falling edge. Directed sections
//   add literal expectations for the key timing and guard cases.
// -----------------------------------------------------------------------------
module tb_cpu_query_sequencer;

  localparam int NODE_W     = 8;
  localparam int MAXQ       = 8;
  localparam int IDX_W      = 3;
  localparam int RST_HOLD   = 4;
  localparam int GAP        = 3;
  localparam int TIMEOUT    = 20;

`ifdef CPU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_GAP = 3, P_DONE = 4, P_ABORT = 5;

  logic              clk_50M = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [NODE_W-1:0] wr_sp;
  logic [NODE_W-1:0] wr_ep;
  logic [IDX_W:0]    num_queries;
  logic              start;
  logic              cpu_done;
  logic [NODE_W-1:0] SP;
  logic [NODE_W-1:0] EP;
  logic              cpu_reset;
  logic              busy;
  logic [IDX_W-1:0]  query_idx;
  logic              query_done;
  logic              seq_done;
  logic              timeout_err;
  logic [2:0]        state;

  int n_total = 0;
  int n_bad   = 0;
  bit cmp_en  = 1'b0;

  always #10 clk_50M = ~clk_50M;

  cpu_query_sequencer #(
    .NODE_W         (NODE_W),
    .MAX_QUERIES    (MAXQ),
    .IDX_W          (IDX_W),
    .RST_HOLD       (RST_HOLD),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (32)
  ) dut (
    .clk_50M     (clk_50M),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_sp       (wr_sp),
    .wr_ep       (wr_ep),
    .num_queries (num_queries),
    .start       (start),
    .cpu_done    (cpu_done),
    .SP          (SP),
    .EP          (EP),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .query_idx   (query_idx),
    .query_done  (query_done),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .state       (state)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_50M);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase plus a countdown of cycles left in the phase.
  // ---------------------------------------------------------------------------
  int          m_phase, m_left, m_age, m_n, m_idx;
  logic [7:0]  m_sp, m_ep;
  bit          m_cpu_reset, m_busy, m_qd, m_seq, m_terr;
  logic [7:0]  m_tbl_sp [MAXQ];
  logic [7:0]  m_tbl_ep [MAXQ];
  bit          m_do_wr;

  always @(posedge clk_50M) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_sp = 0; m_ep = 0; m_cpu_reset = 0; m_busy = 0;
      m_idx = 0; m_qd = 0; m_seq = 0; m_terr = 0; m_left = 0; m_age = 0; m_n = 0;
    end else begin
      m_do_wr = wr_en && (m_phase == P_IDLE || m_phase == P_DONE);
      m_qd = 0;
      case (m_phase)
        P_IDLE, P_DONE, P_ABORT: begin
          if (start && int'(num_queries) >= 1 && int'(num_queries) <= MAXQ) begin
            m_n = int'(num_queries); m_idx = 0;
            m_sp = m_tbl_sp[0]; m_ep = m_tbl_ep[0];
            m_cpu_reset = 1; m_busy = 1; m_seq = 0; m_terr = 0;
            m_left = RST_HOLD; m_phase = P_RST;
          end
        end
        P_RST: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_RUN; m_cpu_reset = 0; m_age = 0; end
        end
        P_RUN: begin
          if (cpu_done) begin
            m_qd = 1;
            if (m_idx == m_n - 1) begin m_phase = P_DONE; m_busy = 0; m_seq = 1; end
            else begin m_phase = P_GAP; m_left = GAP; end
          end else begin
            m_age++;
            if (TO_EN && m_age == TIMEOUT) begin
              m_phase = P_ABORT; m_terr = 1; m_cpu_reset = 1; m_busy = 0;
            end
          end
        end
        P_GAP: begin
          m_left--;
          if (m_left == 0) begin
            m_idx++;
            m_sp = m_tbl_sp[m_idx]; m_ep = m_tbl_ep[m_idx];
            m_cpu_reset = 1; m_left = RST_HOLD; m_phase = P_RST;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (m_do_wr) begin
        m_tbl_sp[wr_idx] = wr_sp;
        m_tbl_ep[wr_idx] = wr_ep;
      end
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk_50M) begin
    if (cmp_en) begin
      check("state",       32'(state),       32'(m_phase));
      check("SP",          32'(SP),          32'(m_sp));
      check("EP",          32'(EP),          32'(m_ep));
      check("cpu_reset",   32'(cpu_reset),   32'(m_cpu_reset));
      check("busy",        32'(busy),        32'(m_busy));
      check("query_idx",   32'(query_idx),   32'(m_idx));
      check("query_done",  32'(query_done),  32'(m_qd));
      check("seq_done",    32'(seq_done),    32'(m_seq));
      check("timeout_err", 32'(timeout_err), 32'(m_terr));
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int i = 0;
    while (state !== s && i < budget) begin
      tick();
      i++;
    end
    check(nm, 32'(state), 32'(s));
  endtask

  task automatic pulse_done();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
  endtask

  task automatic launch(input int n);
    num_queries = 4'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi, t_qd0, t_rst1, n_qd, n_run;
    logic prev_rst;

    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_sp = '0; wr_ep = '0;
    num_queries = '0; start = 1'b0; cpu_done = 1'b0;
    tick();
    cmp_en = 1'b1;
    // Reset state literals
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Program the table: entry 0 {0,7}, entry 1 {5,21}, others random.
    for (int i = 0; i < MAXQ; i++) begin
      wr_en  = 1'b1;
      wr_idx = 3'(i);
      wr_sp  = (i == 0) ? 8'd0 : (i == 1) ? 8'd5  : 8'($urandom);
      wr_ep  = (i == 0) ? 8'd7 : (i == 1) ? 8'd21 : 8'($urandom);
      tick();
    end
    wr_en = 1'b0;

    // Single query: cpu_reset high for exactly RST_HOLD cycles.
    launch(1);
    check("q1_SP", 32'(SP), 32'd0);
    check("q1_EP", 32'(EP), 32'd7);
    check("q1_state", 32'(state), 32'd1);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_reset === 1'b1) hi++;
      tick();
    end
    check("q1_rst_hold", 32'(hi), 32'd4);
    repeat (2) tick();
    pulse_done();
    check("q1_query_done", 32'(query_done), 32'd1);
    check("q1_done_state", 32'(state), 32'd4);
    check("q1_seq_done", 32'(seq_done), 32'd1);
    tick();
    check("q1_pulse_end", 32'(query_done), 32'd0);

    // Two queries with cpu_done held high throughout; write while busy.
    cpu_done = 1'b1;
    launch(2);
    t_qd0 = -1; t_rst1 = -1; n_qd = 0; prev_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (query_done === 1'b1) begin
        n_qd++;
        if (t_qd0 < 0) t_qd0 = i;
      end
      if (cpu_reset === 1'b1 && !prev_rst && t_qd0 >= 0 && t_rst1 < 0) begin
        t_rst1 = i;
        check("q2_SP", 32'(SP), 32'd5);
        check("q2_EP", 32'(EP), 32'd21);
        check("q2_idx", 32'(query_idx), 32'd1);
      end
      prev_rst = cpu_reset;
      if (i == 2) begin wr_en = 1'b1; wr_idx = 3'd0; wr_sp = 8'd99; wr_ep = 8'd98; end
      if (i == 3) wr_en = 1'b0;
      tick();
    end
    cpu_done = 1'b0;
    check("q2_first_done_at", 32'(t_qd0), 32'd5);
    check("q2_gap", 32'(t_rst1 - t_qd0), 32'd3);
    check("q2_done_pulses", 32'(n_qd), 32'd2);
    check("q2_state", 32'(state), 32'd4);

    // Restart from DONE with a same-cycle write: the run sees old entry 0.
    wr_en = 1'b1; wr_idx = 3'd0; wr_sp = 8'd3; wr_ep = 8'd9;
    launch(1);
    wr_en = 1'b0;
    check("rs_seq_done", 32'(seq_done), 32'd0);
    check("rs_SP", 32'(SP), 32'd0);
    check("rs_EP", 32'(EP), 32'd7);
    wait_state(3'd2, 20, "rs_reach_run");
    pulse_done();
    check("rs_done", 32'(state), 32'd4);
    launch(1);
    check("rs2_SP", 32'(SP), 32'd3);
    check("rs2_EP", 32'(EP), 32'd9);
    wait_state(3'd2, 20, "rs2_reach_run");
    pulse_done();

    // Reset in the middle of RUN.
    launch(2);
    wait_state(3'd2, 20, "mr_reach_run");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_state", 32'(state), 32'd0);
    check("mr_cpu_reset", 32'(cpu_reset), 32'd0);
    check("mr_SP", 32'(SP), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);

    // Out-of-range query counts are ignored.
    launch(0);
    check("nq0_state", 32'(state), 32'd0);
    launch(9);
    check("nq9_state", 32'(state), 32'd0);
    check("nq9_busy", 32'(busy), 32'd0);

    launch(1);
    check("fresh_state", 32'(state), 32'd1);
    check("fresh_SP", 32'(SP), 32'd3);
    check("fresh_EP", 32'(EP), 32'd9);
    wait_state(3'd2, 20, "fresh_reach_run");
    pulse_done();

    // RUN with no cpu_done.
    launch(1);
    wait_state(3'd2, 20, "to_reach_run");
`ifdef CPU_TIMEOUT_EN
    n_run = 0;
    while (state === 3'd2 && n_run < 40) begin
      n_run++;
      tick();
    end
    check("to_run_cycles", 32'(n_run), 32'd20);
    check("to_state", 32'(state), 32'd5);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_cpu_reset", 32'(cpu_reset), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    launch(1);
    check("to_restart_state", 32'(state), 32'd1);
    check("to_restart_err", 32'(timeout_err), 32'd0);
    wait_state(3'd2, 20, "to_restart_run");
    pulse_done();
`else
    n_run = 0;
    repeat (120) begin
      tick();
      n_run++;
    end
    check("nto_state", 32'(state), 32'd2);
    check("nto_err", 32'(timeout_err), 32'd0);
    pulse_done();
    check("nto_done", 32'(state), 32'd4);
`endif

    // Randomized phase, checked purely by the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n       = ($urandom_range(0, 599) != 0);
      start       = ($urandom_range(0, 11) == 0);
      num_queries = 4'($urandom_range(0, 9));
      wr_en       = ($urandom_range(0, 3) == 0);
      wr_idx      = 3'($urandom_range(0, 7));
      wr_sp       = 8'($urandom);
      wr_ep       = 8'($urandom);
      cpu_done    = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst_n = 1'b1; start = 1'b0; wr_en = 1'b0; cpu_done = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_cpu_query_sequencer
